// File: rtl/mem_bus_arbiter.sv
// Two-master RAM bus arbiter: CPU owns the bus by default, a DMA master borrows it
// through a req/gnt handshake with bounded bursts and a guaranteed CPU window between them.
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16,
  parameter int CPU_GUARD  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic                  cpu_read,
  input  logic                  cpu_write,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  input  logic                  dma_req,
  output logic                  dma_gnt,
  input  logic                  dma_valid,
  input  logic                  dma_we,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  output logic [DATA_WIDTH-1:0] dma_rdata,
  output logic                  dma_rvalid,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [DATA_WIDTH-1:0] mem_data_out,
  input  logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  cpu_violation
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int GW = (CPU_GUARD < 1) ? 1 : $clog2(CPU_GUARD + 1);

  typedef enum logic [1:0] {S_CPU, S_DMA, S_TURN} state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   burst_q, burst_d;
  logic [GW-1:0]   guard_q, guard_d;
  logic            stall_q, gnt_q, rvalid_q, viol_q;

  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    guard_d = guard_q;
    case (state_q)
      S_CPU: begin
        if (guard_q != '0) guard_d = guard_q - 1'b1;
        // An in-flight CPU strobe always wins over a newly raised request.
        if (dma_req && !cpu_read && !cpu_write && (guard_q == '0)) begin
          state_d = S_DMA;
          burst_d = '0;
        end
      end
      S_DMA: begin
        if (dma_valid) burst_d = burst_q + 1'b1;
        if (!dma_req || (dma_valid && (burst_q == BW'(MAX_BURST - 1))))
          state_d = S_TURN;
      end
      S_TURN: begin
        state_d = S_CPU;
        guard_d = GW'(CPU_GUARD);
      end
      default: state_d = S_CPU;
    endcase
  end

  // Stall is derived from ownership, so CPU strobes are only forwarded in S_CPU.
  always_comb begin
    mem_address  = cpu_addr;
    mem_data_out = cpu_wdata;
    mem_read     = cpu_read;
    mem_write    = cpu_write;
    case (state_q)
      S_DMA: begin
        mem_address  = dma_addr;
        mem_data_out = dma_wdata;
        mem_read     = dma_valid & ~dma_we;
        mem_write    = dma_valid & dma_we;
      end
      S_TURN: begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_CPU;
      burst_q  <= '0;
      guard_q  <= '0;
      stall_q  <= 1'b0;
      gnt_q    <= 1'b0;
      rvalid_q <= 1'b0;
      viol_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      burst_q  <= burst_d;
      guard_q  <= guard_d;
      stall_q  <= (state_d != S_CPU);
      gnt_q    <= (state_d == S_DMA);
      rvalid_q <= (state_q == S_DMA) && dma_valid && !dma_we;
      if (stall_q && (cpu_read || cpu_write)) viol_q <= 1'b1;
    end
  end

  assign cpu_stall     = stall_q;
  assign dma_gnt       = gnt_q;
  assign dma_rvalid    = rvalid_q;
  assign cpu_violation = viol_q;
  assign cpu_rdata     = mem_data_in;
  assign dma_rdata     = mem_data_in;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus a randomized run checked
// against an ownership/memory reference model and a behavioural synchronous RAM.
module tb_mem_bus_arbiter;
  localparam int AW = 16, DW = 8, MB = 16, CG = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] cpu_addr, dma_addr, mem_address;
  logic          cpu_read, cpu_write, cpu_stall, dma_req, dma_gnt, dma_valid, dma_we;
  logic [DW-1:0] cpu_wdata, cpu_rdata, dma_wdata, dma_rdata, mem_data_out;
  logic          dma_rvalid, mem_read, mem_write, cpu_violation;
  logic [DW-1:0] mem_data_in = '0;
  logic [7:0]    ram [0:65535] = '{default: 8'h00};

  int errors = 0;
  int checks = 0;

  mem_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB), .CPU_GUARD(CG)) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_gnt(dma_gnt), .dma_valid(dma_valid), .dma_we(dma_we),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_data_out(mem_data_out), .mem_data_in(mem_data_in), .cpu_violation(cpu_violation)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_write) ram[mem_address] <= mem_data_out;
    if (mem_read)  mem_data_in <= ram[mem_address];
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    cpu_addr = '0; cpu_read = 1'b0; cpu_write = 1'b0; cpu_wdata = '0;
    dma_req = 1'b0; dma_valid = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", cpu_stall); end
    checks++; if (dma_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b want 0", dma_gnt); end
    checks++; if (dma_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b want 0", dma_rvalid); end
    checks++; if (cpu_violation !== 1'b0) begin errors++; $display("FAIL reset_viol: got %b want 0", cpu_violation); end
    @(posedge clk); #1;
    reset = 1'b0;
    step();
    checks++; if ({mem_read, mem_write, dma_gnt, cpu_stall} !== 4'b0) begin
      errors++; $display("FAIL reset_idle: got %b want 0000", {mem_read, mem_write, dma_gnt, cpu_stall}); end
  endtask

  task automatic test_dma_write();
    logic [7:0] wv [3] = '{8'h11, 8'h22, 8'h33};
    dma_req = 1'b1;
    #1;
    checks++; if (dma_gnt !== 1'b0) begin errors++; $display("FAIL wr_gnt_early: got %b want 0", dma_gnt); end
    step();
    checks++; if ({dma_gnt, cpu_stall} !== 2'b11) begin errors++; $display("FAIL wr_grant: got %b want 11", {dma_gnt, cpu_stall}); end
    for (int i = 0; i < 3; i++) begin
      dma_valid = 1'b1; dma_we = 1'b1; dma_addr = 16'h8000 + 16'(i); dma_wdata = wv[i];
      #1;
      checks++; if ({mem_write, mem_read, mem_address, mem_data_out} !== {2'b10, dma_addr, wv[i]}) begin
        errors++; $display("FAIL wr_bus%0d: got w%b r%b a%h d%h want w1 r0 a%h d%h", i, mem_write, mem_read,
                            mem_address, mem_data_out, dma_addr, wv[i]); end
      step();
    end
    dma_valid = 1'b0; dma_req = 1'b0;
    step();
    checks++; if ({dma_gnt, cpu_stall} !== 2'b01) begin errors++; $display("FAIL wr_turn: got %b want 01", {dma_gnt, cpu_stall}); end
    step();
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL wr_release: got %b want 0", cpu_stall); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (ram[16'h8000 + 16'(i)] !== wv[i]) begin
        errors++; $display("FAIL wr_ram%0d: got %h want %h", i, ram[16'h8000 + 16'(i)], wv[i]); end
    end
  endtask

  task automatic test_cpu_priority();
    repeat (CG + 2) step();
    cpu_addr = 16'h0010; cpu_wdata = 8'h5C; cpu_write = 1'b1;
    step();
    cpu_write = 1'b0; cpu_read = 1'b1; dma_req = 1'b1;
    #1;
    checks++; if ({mem_read, mem_write, mem_address} !== {2'b10, 16'h0010}) begin
      errors++; $display("FAIL prio_bus: got r%b w%b a%h want r1 w0 a0010", mem_read, mem_write, mem_address); end
    step();
    checks++; if (dma_gnt !== 1'b0) begin errors++; $display("FAIL prio_wait1: got %b want 0", dma_gnt); end
    checks++; if (cpu_rdata !== 8'h5C) begin errors++; $display("FAIL prio_rdata: got %h want 5c", cpu_rdata); end
    step();
    checks++; if (dma_gnt !== 1'b0) begin errors++; $display("FAIL prio_wait2: got %b want 0", dma_gnt); end
    cpu_read = 1'b0;
    step();
    checks++; if ({dma_gnt, cpu_stall} !== 2'b11) begin errors++; $display("FAIL prio_grant: got %b want 11", {dma_gnt, cpu_stall}); end
    dma_req = 1'b0;
    step(); step();
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL prio_release: got %b want 0", cpu_stall); end
  endtask

  task automatic test_dma_read();
    repeat (CG + 2) step();
    dma_req = 1'b1;
    step();
    dma_valid = 1'b1; dma_we = 1'b0; dma_addr = 16'h8001;
    step();
    checks++; if ({dma_rvalid, dma_gnt, dma_rdata} !== {2'b11, 8'h22}) begin
      errors++; $display("FAIL rd_first: got rv%b g%b d%h want rv1 g1 d22", dma_rvalid, dma_gnt, dma_rdata); end
    dma_addr = 16'h8002; dma_req = 1'b0;
    #1;
    checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL rd_last_strobe: got %b want 1", mem_read); end
    step();
    checks++; if ({dma_gnt, cpu_stall, dma_rvalid, dma_rdata} !== {3'b011, 8'h33}) begin
      errors++; $display("FAIL rd_in_turn: got g%b s%b rv%b d%h want g0 s1 rv1 d33", dma_gnt, cpu_stall, dma_rvalid, dma_rdata); end
    dma_valid = 1'b0;
    step();
    checks++; if ({cpu_stall, dma_rvalid} !== 2'b00) begin errors++; $display("FAIL rd_after: got %b want 00", {cpu_stall, dma_rvalid}); end
  endtask

  task automatic test_max_burst();
    int acc [2];
    int sent, grants, turn, free;
    logic prev;
    acc = '{0, 0}; sent = 0; grants = 0; turn = 0; free = 0; prev = 1'b0;
    repeat (CG + 2) step();
    dma_req = 1'b1;
    for (int c = 0; c < 200 && sent < 20; c++) begin
      step();
      if (dma_gnt) begin
        if (!prev) grants++;
        dma_valid = 1'b1; dma_we = 1'b1;
        dma_addr = 16'h9000 + 16'(sent); dma_wdata = 8'(sent) ^ 8'h5A;
        if (grants >= 1 && grants <= 2) acc[grants-1]++;
        sent++;
      end else begin
        dma_valid = 1'b0;
        if (grants == 1) begin
          if (cpu_stall) turn++; else free++;
        end
      end
      prev = dma_gnt;
    end
    step();
    dma_valid = 1'b0; dma_req = 1'b0;
    step(); step();
    checks++; if (sent !== 20) begin errors++; $display("FAIL burst_sent: got %0d want 20", sent); end
    checks++; if (grants !== 2) begin errors++; $display("FAIL burst_grants: got %0d want 2", grants); end
    checks++; if (acc[0] !== MB) begin errors++; $display("FAIL burst_len1: got %0d want %0d", acc[0], MB); end
    checks++; if (acc[1] !== 20 - MB) begin errors++; $display("FAIL burst_len2: got %0d want %0d", acc[1], 20 - MB); end
    checks++; if (turn !== 1) begin errors++; $display("FAIL burst_turn: got %0d want 1", turn); end
    checks++; if (free < CG) begin errors++; $display("FAIL burst_guard: got %0d want >=%0d", free, CG); end
    for (int i = 0; i < 20; i++) begin
      checks++; if (ram[16'h9000 + 16'(i)] !== (8'(i) ^ 8'h5A)) begin
        errors++; $display("FAIL burst_ram%0d: got %h want %h", i, ram[16'h9000 + 16'(i)], 8'(i) ^ 8'h5A); end
    end
  endtask

  task automatic test_violation();
    repeat (CG + 2) step();
    dma_req = 1'b1;
    step();
    cpu_write = 1'b1; cpu_addr = 16'h0020; cpu_wdata = 8'h99;
    #1;
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL viol_blocked: got %b want 0", mem_write); end
    step();
    checks++; if (cpu_violation !== 1'b1) begin errors++; $display("FAIL viol_set: got %b want 1", cpu_violation); end
    cpu_write = 1'b0; dma_req = 1'b0;
    repeat (5) step();
    checks++; if (cpu_violation !== 1'b1) begin errors++; $display("FAIL viol_sticky: got %b want 1", cpu_violation); end
    checks++; if (ram[16'h0020] !== 8'h00) begin errors++; $display("FAIL viol_ram: got %h want 00", ram[16'h0020]); end
  endtask

  task automatic test_reset_midburst();
    repeat (CG + 2) step();
    dma_req = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      dma_valid = 1'b1; dma_we = 1'b1; dma_addr = 16'hA000 + 16'(i); dma_wdata = 8'(i + 1);
      step();
    end
    dma_addr = 16'hA004; dma_wdata = 8'h44;
    #1;
    reset = 1'b1; dma_req = 1'b0;
    #1;
    checks++; if ({dma_gnt, cpu_stall, dma_rvalid, cpu_violation, mem_write} !== 5'b0) begin
      errors++; $display("FAIL rst_async: got %b want 00000", {dma_gnt, cpu_stall, dma_rvalid, cpu_violation, mem_write}); end
    step(); step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if ({mem_write, dma_gnt} !== 2'b00) begin
        errors++; $display("FAIL rst_after%0d: got %b want 00", i, {mem_write, dma_gnt}); end
    end
    checks++; if (ram[16'hA003] !== 8'h04) begin errors++; $display("FAIL rst_prior: got %h want 04", ram[16'hA003]); end
    checks++; if (ram[16'hA004] !== 8'h00) begin errors++; $display("FAIL rst_aborted: got %h want 00", ram[16'hA004]); end
    clear_inputs();
  endtask

  // Reference: who owns the bus, how many accesses the grant has used, how long the CPU
  // window still has to run, and the expected contents of a 16-byte region.
  task automatic test_random();
    logic       owns, turn, exp_rv, cpu_pend, exp_mr, exp_mw;
    int         window, taken;
    logic [7:0] ref_mem [16];
    logic [7:0] dma_exp, cpu_exp;
    owns = 1'b0; turn = 1'b0; window = 0; taken = 0;
    for (int i = 0; i < 16; i++) ref_mem[i] = ram[16'hB000 + 16'(i)];
    clear_inputs();
    reset = 1'b1;
    #1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 600; c++) begin
      cpu_read = 1'b0; cpu_write = 1'b0; dma_valid = 1'b0;
      if (!owns && !turn) begin
        case ($urandom_range(0, 9))
          0, 1: cpu_read = 1'b1;
          2, 3: cpu_write = 1'b1;
          default: ;
        endcase
      end
      cpu_addr = 16'hB000 + 16'($urandom_range(0, 15)); cpu_wdata = 8'($urandom);
      if (!dma_req) dma_req = ($urandom_range(0, 4) == 0);
      else if (owns && $urandom_range(0, 7) == 0) dma_req = 1'b0;
      if (owns) dma_valid = $urandom_range(0, 1) == 1;
      dma_we = $urandom_range(0, 1) == 1;
      dma_addr = 16'hB000 + 16'($urandom_range(0, 15)); dma_wdata = 8'($urandom);
      #1;
      exp_mr = owns ? (dma_valid & ~dma_we) : (~turn & cpu_read);
      exp_mw = owns ? (dma_valid & dma_we) : (~turn & cpu_write);
      checks++; if ({mem_read, mem_write} !== {exp_mr, exp_mw}) begin
        errors++; $display("FAIL rnd_strobe c%0d: got %b want %b", c, {mem_read, mem_write}, {exp_mr, exp_mw}); end
      exp_rv   = owns & dma_valid & ~dma_we;
      dma_exp  = ref_mem[dma_addr[3:0]];
      cpu_pend = ~owns & ~turn & cpu_read;
      cpu_exp  = ref_mem[cpu_addr[3:0]];
      if (owns && dma_valid && dma_we) ref_mem[dma_addr[3:0]] = dma_wdata;
      if (!owns && !turn && cpu_write) ref_mem[cpu_addr[3:0]] = cpu_wdata;
      if (turn) begin
        turn = 1'b0; window = CG;
      end else if (owns) begin
        if (dma_valid) taken++;
        if (!dma_req || (dma_valid && taken == MB)) begin owns = 1'b0; turn = 1'b1; end
      end else if (dma_req && !cpu_read && !cpu_write && window == 0) begin
        owns = 1'b1; taken = 0;
      end else if (window > 0) begin
        window--;
      end
      step();
      checks++; if ({dma_gnt, cpu_stall, dma_rvalid} !== {owns, owns | turn, exp_rv}) begin
        errors++; $display("FAIL rnd_ctrl c%0d: got %b want %b", c, {dma_gnt, cpu_stall, dma_rvalid}, {owns, owns | turn, exp_rv}); end
      if (exp_rv) begin
        checks++; if (dma_rdata !== dma_exp) begin errors++; $display("FAIL rnd_dma_rdata c%0d: got %h want %h", c, dma_rdata, dma_exp); end
      end
      if (cpu_pend) begin
        checks++; if (cpu_rdata !== cpu_exp) begin errors++; $display("FAIL rnd_cpu_rdata c%0d: got %h want %h", c, cpu_rdata, cpu_exp); end
      end
    end
    clear_inputs();
    step();
    checks++; if (cpu_violation !== 1'b0) begin errors++; $display("FAIL rnd_viol: got %b want 0", cpu_violation); end
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    test_reset();
    test_dma_write();
    test_cpu_priority();
    test_dma_read();
    test_max_burst();
    test_violation();
    test_reset_midburst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Arbitrates the single-port system RAM bus between two requesters: the CPU (default owner, no handshake) and a DMA/program-loader master (req/gnt handshake).
- Sits between the CPU memory interface and the RAM. Stalls the CPU while the DMA master owns the bus.
- Bounds DMA bursts and guarantees the CPU a minimum window between bursts.

Parameters:
ADDR_WIDTH, 16, address bus width
DATA_WIDTH, 8, data bus width
MAX_BURST, 16, maximum DMA accesses per grant (at least 1)
CPU_GUARD, 4, minimum S_CPU cycles after a DMA grant ends before DMA may be granted again

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
cpu_addr  in  ADDR_WIDTH  CPU address
cpu_read  in  1  CPU read strobe
cpu_write  in  1  CPU write strobe
cpu_wdata  in  DATA_WIDTH  CPU write data
cpu_rdata  out  DATA_WIDTH  read data to CPU
cpu_stall  out  1  registered; CPU must freeze its microstep while high
dma_req  in  1  DMA requests the bus; held until done
dma_gnt  out  1  registered; DMA owns the bus
dma_valid  in  1  DMA access this cycle (only honoured while dma_gnt=1)
dma_we  in  1  1 = write, 0 = read
dma_addr  in  ADDR_WIDTH  DMA address
dma_wdata  in  DATA_WIDTH  DMA write data
dma_rdata  out  DATA_WIDTH  read data to DMA
dma_rvalid  out  1  registered; pulses one cycle after an accepted DMA read
mem_address  out  ADDR_WIDTH  RAM address
mem_read  out  1  RAM read strobe
mem_write  out  1  RAM write strobe
mem_data_out  out  DATA_WIDTH  RAM write data
mem_data_in  in  DATA_WIDTH  RAM read data (synchronous RAM, 1-cycle latency)
cpu_violation  out  1  sticky; CPU strobed while stalled

Behaviour:
- Reset (asynchronous, active-high):
  - state = S_CPU; burst_cnt = 0; guard_cnt = 0.
  - cpu_stall = 0, dma_gnt = 0, dma_rvalid = 0, cpu_violation = 0.
  - Reset mid-burst aborts the burst immediately; no further mem strobes are issued from the DMA side.
- State S_CPU:
  - Mem outputs mirror cpu_addr / cpu_read / cpu_write / cpu_wdata combinationally.
  - guard_cnt decrements to 0.
  - Transition to S_DMA when dma_req=1 AND cpu_read=0 AND cpu_write=0 AND guard_cnt=0. A CPU access in progress is never pre-empted.
  - On entry to S_DMA, cpu_stall and dma_gnt go high on the next edge; burst_cnt clears.
- State S_DMA:
  - Mem outputs driven by DMA: mem_read = dma_valid & ~dma_we; mem_write = dma_valid & dma_we.
  - Each dma_valid cycle increments burst_cnt.
  - Exit to S_TURN when dma_req=0, or when an access is accepted with burst_cnt = MAX_BURST-1.
  - On exit, dma_gnt drops on the next edge. The DMA must not assert dma_valid after dma_gnt falls; such accesses are dropped.
- State S_TURN:
  - One cycle; all mem strobes low; cpu_stall still 1. This lets the last DMA read data return.
  - Next state is S_CPU with guard_cnt = CPU_GUARD; cpu_stall drops on that edge.
- Stall protocol:
  - Total stall is 1 (grant) + N accesses/idle cycles + 1 (turnaround).
  - cpu_read/cpu_write high while cpu_stall=1 are not forwarded to RAM and set cpu_violation (sticky until reset).
- Read data:
  - cpu_rdata and dma_rdata both equal mem_data_in (no mux).
  - dma_rvalid = registered (state==S_DMA & dma_valid & ~dma_we). It may assert in the S_TURN cycle for the final read.
- Simultaneous events:
  - dma_req rising in the same cycle as a CPU strobe: CPU wins, DMA waits.
  - dma_req dropping on the cycle of the final MAX_BURST access: that access completes and a single exit to S_TURN occurs.
- Bursts longer than MAX_BURST require dma_req to stay high. The arbiter re-grants after CPU_GUARD cycles in S_CPU, provided the CPU is idle.

Test Plan:
- Idle CPU; dma_req=1, 3 writes (0x8000←0x11, 0x8001←0x22, 0x8002←0x33), then dma_req=0 → dma_gnt/cpu_stall high 1 cycle after req; RAM holds those bytes; cpu_stall low exactly 2 cycles after dma_req drops.
- CPU issues cpu_read of 0x0010 in the cycle dma_req rises → CPU read reaches RAM unchanged; dma_gnt delayed until the first cycle both strobes are 0.
- DMA read of 0x8001 (holds 0x22) → dma_rvalid pulses one cycle later with dma_rdata=0x22; read as the last burst access → rvalid lands in S_TURN.
- dma_req held, 20 consecutive writes with MAX_BURST=16 → grant ends after 16 accesses; S_TURN; at least 4 S_CPU cycles with cpu_stall=0; re-grant completes the remaining 4.
- cpu_write pulse while cpu_stall=1 → mem_write stays low for the CPU access; cpu_violation=1 and remains 1 until reset.
- Assert reset on the 5th access of a burst → all outputs return to reset values asynchronously; after release, CPU owns the bus and no DMA strobe reaches RAM.
